// File: rtl/simon_button_rx.sv
// -----------------------------------------------------------------------------
// simon_button_rx
//
// Return path of the Simon game: samples the four raw player buttons,
// synchronises and debounces each one, and turns a clean single-button press
// into a 2-bit code. The code reaches the game FSM through a one-entry holding
// register with a valid/ready handshake.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_i          synchronous, active-high reset
//   btn_in_i[3:0]  raw asynchronous buttons, active-high
//   btn_held_o     debounced button levels
//   btn_valid_o    an event is pending in the holding register
//   btn_code_o     index of the pending button (meaningful while valid)
//   btn_ready_i    consumer accepts the pending event
//   btn_multi_o    one-cycle pulse: chord detected and rejected
//   btn_overflow_o one-cycle pulse: event dropped, holding register full
//
// Build option:
//   SIMON_RX_RELEASE_EVT_EN  when defined, events fire on button release
//                            instead of press.
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module simon_button_rx #(
   parameter int unsigned DB_COUNT = 10000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] btn_in_i,
   output logic [3:0] btn_held_o,
   output logic       btn_valid_o,
   output logic [1:0] btn_code_o,
   input  logic       btn_ready_i,
   output logic       btn_multi_o,
   output logic       btn_overflow_o
);

   localparam int unsigned CW = $clog2(DB_COUNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

   // True when exactly one bit of v is set.
   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Index of the set bit of a one-hot vector.
   function automatic logic [1:0] enc4(input logic [3:0] v);
      logic [1:0] r;
      case (v)
         4'b0001: r = 2'd0;
         4'b0010: r = 2'd1;
         4'b0100: r = 2'd2;
         4'b1000: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   logic [3:0]    sync1_q, sync2_q;
   logic [3:0]    held_q, held_d;
   logic [3:0]    held_dly_q;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];

   logic          valid_q, valid_d;
   logic [1:0]    code_q, code_d;
   logic          multi_q, multi_d;
   logic          ovf_q, ovf_d;

   logic [3:0]    edge_s;
   logic          evt_s;
   logic          chord_s;
   logic          accept_s;

   // Per-bit debounce: a level change is accepted only after DB_COUNT
   // consecutive mismatching samples; any match restarts the count.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i]  = '0;
         held_d[i] = held_q[i];
         if (sync2_q[i] == held_q[i]) begin
            cnt_d[i]  = '0;
            held_d[i] = held_q[i];
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]  = '0;
            held_d[i] = ~held_q[i];
         end else begin
            cnt_d[i]  = cnt_q[i] + CW'(1);
            held_d[i] = held_q[i];
         end
      end
   end

`ifdef SIMON_RX_RELEASE_EVT_EN
   // Release mode: a lone falling edge with nothing else held is an event;
   // several simultaneous falls are a chord.
   always_comb begin
      edge_s  = ~held_q & held_dly_q;
      evt_s   = 1'b0;
      chord_s = 1'b0;
      if (onehot4(edge_s)) begin
         evt_s   = (held_q == 4'd0);
         chord_s = 1'b0;
      end else if (edge_s != 4'd0) begin
         evt_s   = 1'b0;
         chord_s = 1'b1;
      end else begin
         evt_s   = 1'b0;
         chord_s = 1'b0;
      end
   end
`else
   // Press mode: a lone rising edge with no other button already held is an
   // event; multiple rises, or a rise on top of a held button, is a chord.
   always_comb begin
      edge_s  = held_q & ~held_dly_q;
      evt_s   = 1'b0;
      chord_s = 1'b0;
      if (edge_s == 4'd0) begin
         evt_s   = 1'b0;
         chord_s = 1'b0;
      end else if (onehot4(edge_s) && (held_dly_q == 4'd0)) begin
         evt_s   = 1'b1;
         chord_s = 1'b0;
      end else begin
         evt_s   = 1'b0;
         chord_s = 1'b1;
      end
   end
`endif

   // Holding register next state: load on event when empty or being drained
   // this cycle, otherwise drop the event and flag overflow.
   always_comb begin
      accept_s = valid_q & btn_ready_i;
      valid_d  = valid_q;
      code_d   = code_q;
      multi_d  = chord_s;
      ovf_d    = 1'b0;
      if (evt_s) begin
         if (!valid_q || accept_s) begin
            valid_d = 1'b1;
            code_d  = enc4(edge_s);
         end else begin
            ovf_d   = 1'b1;
         end
      end else if (accept_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers: synchroniser, debounce, edge history, holding register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q    <= 4'd0;
         sync2_q    <= 4'd0;
         held_q     <= 4'd0;
         held_dly_q <= 4'd0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
         valid_q    <= 1'b0;
         code_q     <= 2'd0;
         multi_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         sync1_q    <= btn_in_i;
         sync2_q    <= sync1_q;
         held_q     <= held_d;
         held_dly_q <= held_q;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         valid_q    <= valid_d;
         code_q     <= code_d;
         multi_q    <= multi_d;
         ovf_q      <= ovf_d;
      end
   end

   assign btn_held_o     = held_q;
   assign btn_valid_o    = valid_q;
   assign btn_code_o     = code_q;
   assign btn_multi_o    = multi_q;
   assign btn_overflow_o = ovf_q;

endmodule

// File: tb/tb_simon_button_rx.sv
// -----------------------------------------------------------------------------
// tb_simon_button_rx
//
// Self-checking bench for simon_button_rx (default press-event build) with
// DB_COUNT = 4. Expected button codes are queued when a press is driven and
// popped when the bench accepts an event. Multi/overflow pulses are counted
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_simon_button_rx;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_in;
   logic [3:0] btn_held;
   logic       btn_valid;
   logic [1:0] btn_code;
   logic       btn_ready;
   logic       btn_multi;
   logic       btn_overflow;

   int         pass_cnt = 0;
   int         chk_cnt  = 0;
   int         multi_cnt = 0;
   int         ovf_cnt   = 0;
   logic [1:0] exp_q [$];

   simon_button_rx #(.DB_COUNT(DB)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .btn_in_i       (btn_in),
      .btn_held_o     (btn_held),
      .btn_valid_o    (btn_valid),
      .btn_code_o     (btn_code),
      .btn_ready_i    (btn_ready),
      .btn_multi_o    (btn_multi),
      .btn_overflow_o (btn_overflow)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (btn_multi)    multi_cnt++;
      if (btn_overflow) ovf_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_valid(input int limit, input string name);
      int n;
      n = 0;
      while (!btn_valid && n < limit) begin
         tick();
         n++;
      end
      chk_cnt++;
      if (btn_valid !== 1'b1)
         $display("FAIL %s_wait: btn_valid=%b after %0d cycles, required 1", name, btn_valid, n);
      else
         pass_cnt++;
   endtask

   task automatic accept_evt(input string name);
      logic [1:0] exp;
      chk_cnt++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s_sb: no expected event queued, got valid=%b code=%0d", name, btn_valid, btn_code);
      end else begin
         exp = exp_q.pop_front();
         if (btn_valid !== 1'b1 || btn_code !== exp)
            $display("FAIL %s_code: valid=%b code=%0d, required valid=1 code=%0d", name, btn_valid, btn_code, exp);
         else
            pass_cnt++;
      end
      btn_ready = 1'b1;
      tick();
      btn_ready = 1'b0;
      chk_cnt++;
      if (btn_valid !== 1'b0)
         $display("FAIL %s_drain: btn_valid=%b after accept, required 0", name, btn_valid);
      else
         pass_cnt++;
   endtask

   task automatic release_all(input string name);
      btn_in = 4'b0000;
      ticks(10);
      chk_cnt++;
      if (btn_held !== 4'b0000)
         $display("FAIL %s_release: btn_held=%b, required 0000", name, btn_held);
      else
         pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_in = 4'b0000; btn_ready = 1'b0;
      ticks(3);
      rst = 1'b0;
      tick();
      chk_cnt++;
      if ({btn_held, btn_valid, btn_code, btn_multi, btn_overflow} !== 9'd0)
         $display("FAIL reset_state: outputs=%b, required 0", {btn_held, btn_valid, btn_code, btn_multi, btn_overflow});
      else
         pass_cnt++;
   endtask

   task automatic test_clean_press();
      btn_in = 4'b0100;
      exp_q.push_back(2'd2);
      ticks(5);                         // edges 0..4
      chk_cnt++;
      if (btn_held !== 4'b0000) $display("FAIL clean_held_early: btn_held=%b, required 0000", btn_held);
      else pass_cnt++;
      tick();                           // edge 5
      chk_cnt++;
      if (btn_held !== 4'b0100 || btn_valid !== 1'b0)
         $display("FAIL clean_held: held=%b valid=%b, required 0100/0", btn_held, btn_valid);
      else pass_cnt++;
      tick();                           // edge 6
      chk_cnt++;
      if (btn_valid !== 1'b1) $display("FAIL clean_valid: btn_valid=%b, required 1", btn_valid);
      else pass_cnt++;
      ticks(3);
      chk_cnt++;
      if (btn_valid !== 1'b1 || btn_code !== 2'd2)
         $display("FAIL clean_hold: valid=%b code=%0d, required 1/2", btn_valid, btn_code);
      else pass_cnt++;
      accept_evt("clean");
      release_all("clean");
   endtask

   task automatic test_bounce();
      int m0, o0;
      m0 = multi_cnt; o0 = ovf_cnt;
      btn_in = 4'b0001; tick();
      btn_in = 4'b0000; tick();
      btn_in = 4'b0001; tick();
      btn_in = 4'b0000; tick();
      btn_in = 4'b0001;
      exp_q.push_back(2'd0);
      ticks(5);                         // edges 0..4 of the steady level
      chk_cnt++;
      if (btn_held !== 4'b0000) $display("FAIL bounce_held_early: btn_held=%b, required 0000", btn_held);
      else pass_cnt++;
      tick();                           // edge 5
      chk_cnt++;
      if (btn_held !== 4'b0001) $display("FAIL bounce_held: btn_held=%b, required 0001", btn_held);
      else pass_cnt++;
      wait_valid(4, "bounce");
      accept_evt("bounce");
      ticks(5);
      chk_cnt++;
      if (btn_valid !== 1'b0 || multi_cnt != m0 || ovf_cnt != o0)
         $display("FAIL bounce_single: valid=%b multi=%0d ovf=%0d, required 0/%0d/%0d", btn_valid, multi_cnt, ovf_cnt, m0, o0);
      else pass_cnt++;
      release_all("bounce");
   endtask

   task automatic test_chord();
      int m0;
      m0 = multi_cnt;
      btn_in = 4'b1010;
      ticks(10);
      chk_cnt++;
      if (multi_cnt != m0 + 1 || btn_valid !== 1'b0)
         $display("FAIL chord_dual: multi pulses=%0d valid=%b, required %0d/0", multi_cnt - m0, btn_valid, 1);
      else pass_cnt++;
      btn_in = 4'b1110;
      ticks(10);
      chk_cnt++;
      if (multi_cnt != m0 + 2 || btn_valid !== 1'b0 || btn_held !== 4'b1110)
         $display("FAIL chord_onheld: multi pulses=%0d valid=%b held=%b, required 2/0/1110", multi_cnt - m0, btn_valid, btn_held);
      else pass_cnt++;
      release_all("chord");
      chk_cnt++;
      if (multi_cnt != m0 + 2 || btn_valid !== 1'b0)
         $display("FAIL chord_after: multi pulses=%0d valid=%b, required 2/0", multi_cnt - m0, btn_valid);
      else pass_cnt++;
   endtask

   task automatic test_overflow();
      int o0;
      o0 = ovf_cnt;
      btn_in = 4'b1000;
      exp_q.push_back(2'd3);
      wait_valid(12, "ovf_first");
      release_all("ovf_first");
      btn_in = 4'b0010;
      ticks(10);
      chk_cnt++;
      if (ovf_cnt != o0 + 1 || btn_valid !== 1'b1 || btn_code !== 2'd3)
         $display("FAIL overflow: pulses=%0d valid=%b code=%0d, required 1/1/3", ovf_cnt - o0, btn_valid, btn_code);
      else pass_cnt++;
      release_all("ovf_second");
      accept_evt("overflow");
   endtask

   task automatic test_back_to_back();
      int o0;
      logic [1:0] exp;
      o0 = ovf_cnt;
      btn_in = 4'b0001;
      exp_q.push_back(2'd0);
      wait_valid(12, "b2b_first");
      release_all("b2b_first");
      btn_in = 4'b0100;
      exp_q.push_back(2'd2);
      ticks(6);                         // edges 0..5, event lands on edge 6
      chk_cnt++;
      if (btn_held !== 4'b0100 || btn_valid !== 1'b1 || btn_code !== 2'd0)
         $display("FAIL b2b_pre: held=%b valid=%b code=%0d, required 0100/1/0", btn_held, btn_valid, btn_code);
      else pass_cnt++;
      exp = exp_q.pop_front();
      chk_cnt++;
      if (btn_code !== exp) $display("FAIL b2b_first_code: code=%0d, required %0d", btn_code, exp);
      else pass_cnt++;
      btn_ready = 1'b1;
      tick();                           // accept and load on the same edge
      btn_ready = 1'b0;
      chk_cnt++;
      if (btn_valid !== 1'b1 || btn_code !== 2'd2)
         $display("FAIL b2b_load: valid=%b code=%0d, required 1/2", btn_valid, btn_code);
      else pass_cnt++;
      ticks(3);
      chk_cnt++;
      if (ovf_cnt != o0) $display("FAIL b2b_no_ovf: overflow pulses=%0d, required 0", ovf_cnt - o0);
      else pass_cnt++;
      accept_evt("b2b");
      release_all("b2b");
   endtask

   task automatic test_reset_mid();
      btn_in = 4'b0010;
      ticks(3);                         // partway through debounce
      rst = 1'b1; tick(); rst = 1'b0;
      chk_cnt++;
      if ({btn_held, btn_valid, btn_code, btn_multi, btn_overflow} !== 9'd0)
         $display("FAIL rst_debounce: outputs=%b, required 0", {btn_held, btn_valid, btn_code, btn_multi, btn_overflow});
      else pass_cnt++;
      ticks(6);
      chk_cnt++;
      if (btn_valid !== 1'b0) $display("FAIL rst_early_valid: btn_valid=%b, required 0", btn_valid);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (btn_valid !== 1'b1 || btn_code !== 2'd1)
         $display("FAIL rst_refire: valid=%b code=%0d, required 1/1", btn_valid, btn_code);
      else pass_cnt++;
      rst = 1'b1; tick(); rst = 1'b0;   // discard the pending event
      chk_cnt++;
      if ({btn_held, btn_valid, btn_code, btn_multi, btn_overflow} !== 9'd0)
         $display("FAIL rst_pending: outputs=%b, required 0", {btn_held, btn_valid, btn_code, btn_multi, btn_overflow});
      else pass_cnt++;
      exp_q.push_back(2'd1);
      ticks(6);
      chk_cnt++;
      if (btn_valid !== 1'b0) $display("FAIL rst2_early_valid: btn_valid=%b, required 0", btn_valid);
      else pass_cnt++;
      tick();
      accept_evt("rst_refire2");
      release_all("rst");
   endtask

   initial begin
      rst = 1'b1; btn_in = 4'b0000; btn_ready = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_chord();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL sb_empty: %0d events never seen, required 0", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/simon_button_rx.md
# simon_button_rx

Input-side companion to the Simon game core. The core drives LEDs and tones out to the player; this block handles the return path. It samples the four raw player buttons, synchronises and debounces each one, and turns each clean press into a 2-bit button code. The code is handed to the game FSM over a valid/ready handshake through a one-entry holding register.

## Interface
- `DB_COUNT`, default 10000: consecutive stable cycles required to accept a level change. Legal range 2..65535. Counter width is `$clog2(DB_COUNT+1)`.
- `clk` in 1: sole clock; all flops on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `btn_in` in 4: raw buttons, asynchronous, active-high; bit i is button i.
- `btn_held` out 4: debounced button levels.
- `btn_valid` out 1: an event is pending in the holding register.
- `btn_code` out 2: index of the pending button; meaningful only while `btn_valid` is high.
- `btn_ready` in 1: the consumer accepts the pending event.
- `btn_multi` out 1: one-cycle pulse when a chord is detected and rejected.
- `btn_overflow` out 1: one-cycle pulse when an event is dropped because the holding register is full.

## Operation
- **Synchroniser:** two flops per bit, `sync1` then `sync2`.
- **Debounce (per bit):**
  - If `sync2[i] == btn_held[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - When it reaches `DB_COUNT-1` with the mismatch still present, `btn_held[i]` toggles and the counter clears in the same edge.
  - Any bounce back to the held level clears the counter, so acceptance needs `DB_COUNT` consecutive mismatching samples.
- **Edge detect:** `rise[i] = btn_held[i] & ~held_d[i]`, where `held_d` is `btn_held` delayed one cycle.
- **Event rule, press mode:**
  - Exactly one `rise` bit set, and no other `held_d` bit set: generate an event with code = index of that bit.
  - More than one `rise` bit, or a rise while another button is already held: pulse `btn_multi`, no event.
- **Holding register:**
  - On an event: if `btn_valid` is 0, or the pending event is being accepted this cycle (`btn_valid & btn_ready`), load `btn_code` and set `btn_valid`.
  - Otherwise drop the event, pulse `btn_overflow`, and keep the old code.
  - `btn_valid & btn_ready` with no new event: clear `btn_valid`.
  - Accept and new event in the same cycle: `btn_valid` stays 1 and `btn_code` takes the new index.
- **Handshake rules:**
  - `btn_code` is stable while `btn_valid` is high and not yet accepted.
  - `btn_ready` is ignored while `btn_valid` is 0.
- **Reset:** `sync1`, `sync2`, `btn_held`, `held_d` and all counters clear to 0. `btn_valid`, `btn_code`, `btn_multi` and `btn_overflow` clear to 0.
  - Reset mid-debounce discards the partial count.
  - Reset with an event pending discards it.
  - A button held through reset deassertion is re-debounced and produces a fresh event.

## Timing
- Edge 0 is the first rising edge that samples the new `btn_in` level. With a clean input:
  - `sync2` changes after edge 1.
  - `btn_held` changes after edge `DB_COUNT+1`.
  - `btn_valid` rises after edge `DB_COUNT+2`.
- Press-to-valid latency is `DB_COUNT+3` cycles counted from edge 0 inclusive.
- The accepting edge (`btn_valid & btn_ready` high) clears `btn_valid` after that edge. The consumer sees zero wait.
- `btn_multi` and `btn_overflow` pulse for exactly one cycle, aligned with the cycle `btn_valid` would have risen.
- No combinational path from any input to any output.

## Configuration
- `SIMON_RX_RELEASE_EVT_EN` undefined: events fire on press, as described above.
- `SIMON_RX_RELEASE_EVT_EN` defined: events fire on release instead.
  - Uses `fall[i] = ~btn_held[i] & held_d[i]`.
  - Valid when exactly one bit falls and no other `btn_held` bit is 1.
  - Simultaneous falls pulse `btn_multi`.
  - Press edges generate nothing.
  - Timing is otherwise identical. The game core plays the button's tone for the whole duration it is held.

## Test plan
- **Clean press:** `DB_COUNT=4`, raise `btn_in=4'b0100` and hold, `btn_ready=0`.
  - `btn_held=4'b0100` after edge 5.
  - `btn_valid=1` and `btn_code=2` after edge 6.
  - Both hold until `btn_ready=1`; `btn_valid=0` after the accepting edge.
- **Bounce:** toggle bit 0 as 1,0,1,0 on successive cycles, then hold 1.
  - No `btn_held` change until 4 consecutive high samples.
  - Exactly one event, code 0.
- **Chord:** raise bits 1 and 3 in the same cycle → one `btn_multi` pulse, `btn_valid` stays 0.
  - Then raise bit 2 while bit 1 is held → another `btn_multi` pulse.
- **Overflow:** press button 3 with `btn_ready=0`, release, then press button 1.
  - `btn_overflow` pulses once.
  - `btn_code` stays 3.
- **Accept-and-load:** with `btn_valid` holding code 0, the new event for button 2 lands on the same edge as `btn_ready=1`.
  - `btn_valid` stays 1.
  - `btn_code=2`.
  - No overflow pulse.
- **Reset mid-operation:** assert `rst` for 1 cycle during a debounce count, and again with `btn_valid=1`.
  - All outputs read 0 after the reset edge.
  - A button held throughout yields `btn_valid` again 7 cycles after `rst` is released.
